// File: rtl/tl_d_burst_arbiter_pkg.sv
// Shared TileLink D-channel helpers and the arbiter's lock state type.
// Beat counting lives here so every TL block derives burst length the same way.
package tl_d_burst_arbiter_pkg;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_HINT_ACK        = 3'd2,
        D_GRANT           = 3'd4,
        D_GRANT_DATA      = 3'd5,
        D_RELEASE_ACK     = 3'd6
    } tl_d_op_e;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic tl_d_has_data(input logic [2:0] opcode);
        return (opcode == D_ACCESS_ACK_DATA) || (opcode == D_GRANT_DATA);
    endfunction

    // Beats in a message: data messages wider than one bus word span several beats.
    function automatic int unsigned tl_beats(input logic [2:0] opcode,
                                             input int unsigned size,
                                             input int unsigned data_width);
        int unsigned off_w;
        off_w = 0;
        for (int unsigned w = 8; w < data_width; w = w * 2) begin
            off_w = off_w + 1;
        end
        if (tl_d_has_data(opcode) && (size > off_w)) begin
            return 32'd1 << (size - off_w);
        end
        return 32'd1;
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module tl_rr_pick #(
    parameter  int unsigned NumReq = 3,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   idx,
    output logic              any
);

    always_comb begin
        logic [IdxW-1:0] j;
        j   = '0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            j = IdxW'((32'(ptr) + k) % NumReq);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/tl_d_burst_arbiter.sv
// Burst-aware round-robin arbiter merging several TileLink D sources onto one channel.
// state      | meaning
// ARB_OPEN   | arbitrating per message; grant follows tl_rr_pick
// ARB_LOCKED | mid-burst; selection pinned to sel_q until the last beat
module tl_d_burst_arbiter
    import tl_d_burst_arbiter_pkg::*;
#(
    parameter  int unsigned NumReq       = 3,
    parameter  int unsigned DataWidth    = 64,
    parameter  int unsigned MaxSize      = 6,
    parameter  int unsigned PayloadWidth = 80,
    localparam int unsigned SizeW        = $clog2(MaxSize + 1),
    localparam int unsigned IdxW         = $clog2(NumReq)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              req_valid_i,
    output logic [NumReq-1:0]              req_ready_o,
    input  logic [NumReq*3-1:0]            req_opcode_i,
    input  logic [NumReq*SizeW-1:0]        req_size_i,
    input  logic [NumReq*PayloadWidth-1:0] req_payload_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [2:0]                     out_opcode_o,
    output logic [SizeW-1:0]               out_size_o,
    output logic [PayloadWidth-1:0]        out_payload_o,
    output logic [IdxW-1:0]                out_idx_o,
    output logic                           out_first_o,
    output logic                           out_last_o
);

    localparam int unsigned OffW  = $clog2(DataWidth / 8);
    localparam int unsigned BeatW = (MaxSize > OffW + 1) ? (MaxSize - OffW) : 1;

    arb_state_e         locked_q, locked_d;
    logic [NumReq-1:0]  sel_q, sel_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;

    logic [NumReq-1:0]  gnt;
    logic [IdxW-1:0]    gnt_idx;
    logic               gnt_any;
    logic [NumReq-1:0]  sel;
    logic [IdxW-1:0]    sel_idx;
    int unsigned        beats;

    tl_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .req (req_valid_i),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    always_comb begin
        sel           = (locked_q == ARB_LOCKED) ? sel_q : gnt;
        sel_idx       = gnt_idx;
        out_opcode_o  = '0;
        out_size_o    = '0;
        out_payload_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (sel[i]) begin
                sel_idx       = IdxW'(i);
                out_opcode_o  = req_opcode_i[3*i +: 3];
                out_size_o    = req_size_i[SizeW*i +: SizeW];
                out_payload_o = req_payload_i[PayloadWidth*i +: PayloadWidth];
            end
        end
        // A locked source that drops valid stalls the channel rather than yielding it.
        out_valid_o = (locked_q == ARB_LOCKED) ? |(req_valid_i & sel_q) : gnt_any;
        req_ready_o = sel & {NumReq{out_ready_i}};
        out_idx_o   = sel_idx;
        beats       = tl_beats(out_opcode_o, 32'(out_size_o), DataWidth);
        out_first_o = (beat_q == '0);
        out_last_o  = (32'(beat_q) == (beats - 32'd1));
    end

    always_comb begin
        locked_d = locked_q;
        sel_d    = sel_q;
        beat_d   = beat_q;
        ptr_d    = ptr_q;
        if (out_valid_o && out_ready_i) begin
            if (out_last_o) begin
                locked_d = ARB_OPEN;
                beat_d   = '0;
                ptr_d    = (sel_idx == IdxW'(NumReq - 1)) ? '0 : (sel_idx + 1'b1);
            end else begin
                locked_d = ARB_LOCKED;
                beat_d   = beat_q + 1'b1;
                sel_d    = sel;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_q <= ARB_OPEN;
            sel_q    <= '0;
            beat_q   <= '0;
            ptr_q    <= '0;
        end else begin
            locked_q <= locked_d;
            sel_q    <= sel_d;
            beat_q   <= beat_d;
            ptr_q    <= ptr_d;
        end
    end

endmodule

// File: doc/tl_d_burst_arbiter.md
Name: tl_d_burst_arbiter

Overview:
Burst-aware N-way arbiter sharing one TileLink D channel among several internal response sources (device responses, locally generated denials, ReleaseAcks).
- Round-robin selection between messages.
- Grant held for all beats of a multi-beat data message.
- Provides first/last beat flags and the winning index, so sink-injection logic downstream needs no separate burst tracker.
- Used by ROM/IO terminators and adapters that merge several D sources.

Parameters:
NumReq, 3, number of requesting sources (>=2)
DataWidth, 64, D data width in bits (power of 2, >=8)
MaxSize, 6, log2 of largest transfer in bytes
PayloadWidth, 80, width of opaque per-beat payload (param/source/denied/corrupt/data), passed through untouched

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
req_valid_i  input  NumReq  per-source beat valid
req_ready_o  output  NumReq  per-source beat accepted
req_opcode_i  input  NumReq*3  per-source D opcode, packed, source i at [3i+:3]
req_size_i  input  NumReq*SizeW  per-source log2 size; SizeW = $clog2(MaxSize+1)
req_payload_i  input  NumReq*PayloadWidth  per-source payload
out_valid_o  output  1  merged beat valid
out_ready_i  input  1  downstream ready
out_opcode_o  output  3  selected opcode
out_size_o  output  SizeW  selected size
out_payload_o  output  PayloadWidth  selected payload
out_idx_o  output  $clog2(NumReq)  index of selected source
out_first_o  output  1  current beat is first of its message
out_last_o  output  1  current beat is last of its message

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous, active-high.
- Beats per message:
  - Message has data iff opcode is AccessAckData(1) or GrantData(5).
  - OffW = log2(DataWidth/8).
  - beats = 2^(size-OffW) if data and size > OffW; otherwise 1.
- State:
  - locked_q (1b).
  - sel_q (one-hot, NumReq).
  - beat_q (counter, width max(1, MaxSize-OffW)).
  - ptr_q (round-robin pointer, $clog2(NumReq)).
- Arbitration, when not locked:
  - Grant goes to the first valid source scanning ptr_q, ptr_q+1, ..., wrapping modulo NumReq.
  - Purely combinational: zero-cycle latency from req_valid_i to out_valid_o.
- Output selection:
  - Selected source = locked_q ? sel_q : current grant.
  - out_valid_o = req_valid_i[selected]; out_* fields are muxed from the selected source.
  - req_ready_o[i] = selected[i] & out_ready_i; all other readies are 0.
- Beat flags:
  - out_first_o = (beat_q == 0).
  - out_last_o = (beat_q == beats-1), computed from the selected source's current opcode/size.
- Handshake (out_valid_o & out_ready_i):
  - Non-last beat: beat_q++; locked_q<=1; sel_q<=selected.
  - Last beat: beat_q<=0; locked_q<=0; ptr_q<=(selected index+1) mod NumReq.
  - Single-beat messages never set the lock.
- Lock invariants:
  - While locked, the arbiter never switches, even if the locked source drops valid mid-burst. out_valid_o then goes 0 and the lock is held.
  - Other sources see req_ready_o=0 while locked.
- Source contract: a source holds opcode/size stable for all beats of a message; the bench asserts this.
- out_ready_i low: no state change; selection is stable while valid is held and not locked, because ptr_q changes only on last-beat handshake.
- Reset (including mid-burst): locked_q=0, sel_q=0, beat_q=0, ptr_q=0. Outputs after reset: out_valid_o=0 if no requests, out_first_o=1, req_ready_o all 0 if no requests.
- Counter wrap: beat_q never exceeds beats-1; at MaxSize=6, DataWidth=64 it counts 0..7.

Decomposition:
- tl_pkg additions:
  - Function tl_d_has_data(opcode).
  - Function tl_beats(opcode, size, DataWidth).
  - These replace ad-hoc checks in other TL blocks.
- Sub-module tl_rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: request vector, pointer. Outputs: one-hot grant, index, any.
  - Reusable by A/C channel muxes.

Test Plan:
- Reset then idle: out_valid_o=0, out_first_o=1, req_ready_o=0.
- Sources 0,1,2 each post a single-beat AccessAck (size 3), out_ready_i=1 -> served in order 0,1,2 on consecutive cycles; each beat has first=last=1.
- Source 1 posts GrantData size 6 (8 beats); source 0 asserts valid at beat 2 -> source 1 keeps all 8 beats, idx=1, last only on beat 8; source 0 wins on the next cycle.
- Source 1 drops valid for 3 cycles mid-burst while source 2 is valid -> out_valid_o=0 in those cycles, req_ready_o[2]=0, burst resumes at correct beat_q.
- Backpressure: out_ready_i toggles 1010 during a 4-beat AccessAckData (size 5) -> exactly 4 handshakes, payload order preserved, beat_q correct.
- rst_i asserted at beat 3 of an 8-beat burst -> next cycle locked_q=0, ptr_q=0, lowest-index valid source wins with out_first_o=1.
